// File: rtl/rr_disp.sv
// Round-robin packet dispatcher: steers each whole packet of one input stream
// to one of CH_NUM channels, rotating over the channels that report a free slot.
module rr_disp #(
    parameter int CH_NUM  = 4,
    parameter int ID_WID  = $clog2(CH_NUM),
    parameter int DAT_WID = 64,
    parameter int DBG_WID = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_vld,
    input  logic               s_sop,
    input  logic               s_eop,
    input  logic [DAT_WID-1:0] s_dat,
    output logic               s_rdy,
    input  logic [CH_NUM-1:0]  ch_avail,
    output logic [CH_NUM-1:0]  m_vld,
    output logic               m_sop,
    output logic               m_eop,
    output logic [DAT_WID-1:0] m_dat,
    input  logic [CH_NUM-1:0]  m_rdy,
    output logic [ID_WID-1:0]  cur_id,
    output logic               busy,
    output logic [DBG_WID-1:0] dbg_sig
);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_WID-1:0] sel_id_q, sel_id_d;
    logic [ID_WID-1:0] last_id_q, last_id_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              first_q, first_d;

    logic [ID_WID-1:0] hi_pick, lo_pick, pick;
    logic              hi_found;
    logic              up_xfer;
    logic              err_inc;

    // Wrap-around search: prefer the lowest available channel above last_id,
    // otherwise fall back to the lowest available channel overall.
    always_comb begin
        hi_pick  = '0;
        lo_pick  = '0;
        hi_found = 1'b0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (ch_avail[k]) begin
                lo_pick = ID_WID'(k);
            end
            if (ch_avail[k] && (ID_WID'(k) > last_id_q)) begin
                hi_pick  = ID_WID'(k);
                hi_found = 1'b1;
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    always_comb begin
        state_d   = state_q;
        sel_id_d  = sel_id_q;
        last_id_d = last_id_q;
        pkt_cnt_d = pkt_cnt_q;
        first_d   = first_q;
        err_inc   = 1'b0;
        up_xfer   = 1'b0;
        s_rdy     = 1'b0;
        m_vld     = '0;
        case (state_q)
            IDLE: begin
                // Orphan beats are swallowed; s_rdy is held low while reset is applied.
                s_rdy = s_vld & ~s_sop & ~rst;
                if (s_vld && s_sop && (ch_avail != '0)) begin
                    sel_id_d = pick;
                    first_d  = 1'b1;
                    state_d  = XFER;
                end else if (s_vld && !s_sop) begin
                    err_inc = 1'b1;
                end
            end
            XFER: begin
                s_rdy   = m_rdy[sel_id_q];
                m_vld   = s_vld ? (CH_NUM'(1) << sel_id_q) : '0;
                up_xfer = s_vld & m_rdy[sel_id_q];
                if (up_xfer) begin
                    first_d = 1'b0;
                    if (s_sop && !first_q) begin
                        err_inc = 1'b1;
                    end
                    if (s_eop) begin
                        last_id_d = sel_id_q;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_id_q  <= '0;
            last_id_q <= ID_WID'(CH_NUM - 1);
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_id_q  <= sel_id_d;
            last_id_q <= last_id_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
        end
    end

    assign m_sop  = s_sop;
    assign m_eop  = s_eop;
    assign m_dat  = s_dat;
    assign cur_id = sel_id_q;
    assign busy   = (state_q == XFER);

    logic [31:0] dbg_full;
    assign dbg_full = {7'(sel_id_q), (state_q == XFER), err_cnt_q, pkt_cnt_q};

    generate
        if (DBG_WID <= 32) begin : g_dbg_trunc
            assign dbg_sig = dbg_full[DBG_WID-1:0];
        end else begin : g_dbg_ext
            assign dbg_sig = {{(DBG_WID-32){1'b0}}, dbg_full};
        end
    endgenerate

endmodule

// File: tb/tb_rr_disp.sv
// Directed bench for rr_disp: a packet-level reference model checked every cycle,
// plus hand-computed expectations for rotation, skipping, stalls, errors and reset.
module tb_rr_disp;

    localparam int CH = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_vld, s_sop, s_eop;
    logic [DW-1:0] s_dat;
    logic          s_rdy;
    logic [CH-1:0] ch_avail;
    logic [CH-1:0] m_vld;
    logic          m_sop, m_eop;
    logic [DW-1:0] m_dat;
    logic [CH-1:0] m_rdy;
    logic [1:0]    cur_id;
    logic          busy;
    logic [31:0]   dbg_sig;

    int checks = 0;
    int errors = 0;

    rr_disp #(.CH_NUM(CH), .DAT_WID(DW), .DBG_WID(32)) dut (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_sop(s_sop), .s_eop(s_eop), .s_dat(s_dat), .s_rdy(s_rdy),
        .ch_avail(ch_avail),
        .m_vld(m_vld), .m_sop(m_sop), .m_eop(m_eop), .m_dat(m_dat), .m_rdy(m_rdy),
        .cur_id(cur_id), .busy(busy), .dbg_sig(dbg_sig)
    );

    always #5 clk = ~clk;

    // Packet-level reference model.
    bit          model_init = 1'b0;
    bit          md_busy, md_first;
    int          md_sel, md_last;
    logic [15:0] md_pkt;
    logic [7:0]  md_err;

    int            log_ch[$];
    logic [DW-1:0] log_dat[$];

    function automatic int rr_pick(input logic [CH-1:0] avail, input int last);
        for (int j = 1; j <= CH; j++) begin
            if (avail[(last + j) % CH]) return (last + j) % CH;
        end
        return -1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic exp_s_rdy();
        if (rst) return 1'b0;
        if (md_busy) return m_rdy[md_sel];
        return s_vld && !s_sop;
    endfunction

    function automatic logic [CH-1:0] exp_m_vld();
        logic [CH-1:0] v;
        v = '0;
        if (md_busy && s_vld) v[md_sel] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_dbg();
        return {7'(md_sel), md_busy, md_err, md_pkt};
    endfunction

    function automatic int onehot_idx(input logic [CH-1:0] v);
        for (int k = 0; k < CH; k++) begin
            if (v == (CH'(1) << k)) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_busy    <= 1'b0;
            md_first   <= 1'b0;
            md_sel     <= 0;
            md_last    <= CH - 1;
            md_pkt     <= '0;
            md_err     <= '0;
            model_init <= 1'b1;
        end else if (model_init) begin
            if (!md_busy) begin
                if (s_vld && s_sop && ch_avail != '0) begin
                    md_sel   <= rr_pick(ch_avail, md_last);
                    md_busy  <= 1'b1;
                    md_first <= 1'b1;
                end else if (s_vld && !s_sop) begin
                    md_err <= sat_inc(md_err);
                end
            end else if (s_vld && m_rdy[md_sel]) begin
                md_first <= 1'b0;
                if (s_sop && !md_first) md_err <= sat_inc(md_err);
                if (s_eop) begin
                    md_last <= md_sel;
                    md_pkt  <= md_pkt + 16'd1;
                    md_busy <= 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, plus a log of delivered beats.
    always @(negedge clk) begin
        if (model_init) begin
            check_output("s_rdy", s_rdy, exp_s_rdy());
            check_output("m_vld", m_vld, exp_m_vld());
            check_output("busy", busy, md_busy);
            check_output("cur_id", cur_id, md_sel);
            check_output("m_sop", m_sop, s_sop);
            check_output("m_eop", m_eop, s_eop);
            check_output("m_dat", m_dat, s_dat);
            check_output("dbg_sig", dbg_sig, exp_dbg());
            for (int k = 0; k < CH; k++) begin
                if (m_vld[k] && m_rdy[k] && !rst) begin
                    log_ch.push_back(k);
                    log_dat.push_back(m_dat);
                end
            end
        end
    end

    // Drives one packet beat by beat; optional stall, ch_avail drop, nested sop or reset abort.
    task automatic apply_stimulus(input int nbeats, input logic [DW-1:0] base, input int exp_ch,
                                  input int stall_beat, input int stall_len, input bit drop_avail,
                                  input bit nested, input int abort_after,
                                  output int ch, output int cycles);
        int beat = 0;
        int guard = 0;
        bit acc;
        bit stalled = 1'b0;
        bit aborted = 1'b0;
        ch = -1;
        cycles = 0;
        while (beat < nbeats && guard < 500) begin
            s_vld = 1'b1;
            s_sop = (beat == 0) || (nested && beat == 1);
            s_eop = (beat == nbeats - 1);
            s_dat = base + DW'(beat);
            if (beat == stall_beat && !stalled) begin
                stalled = 1'b1;
                m_rdy = ~(CH'(1) << exp_ch);
                repeat (stall_len) begin
                    @(negedge clk);
                    check_output("stall_s_rdy", s_rdy, 1'b0);
                    check_output("stall_m_vld", m_vld, CH'(1) << exp_ch);
                    @(posedge clk); #1;
                    cycles++;
                end
                m_rdy = '1;
            end
            @(negedge clk);
            acc = s_rdy;
            if (acc && beat == 0) ch = onehot_idx(m_vld);
            @(posedge clk); #1;
            cycles++;
            guard++;
            if (acc) begin
                if (beat == 0 && drop_avail) ch_avail = ch_avail & ~(CH'(1) << exp_ch);
                beat++;
                if (beat == abort_after) begin
                    s_vld = 1'b1;
                    s_sop = 1'b0;
                    s_eop = 1'b0;
                    s_dat = base + DW'(beat);
                    rst = 1'b1;
                    #1;
                    check_output("rst_m_vld", m_vld, '0);
                    check_output("rst_s_rdy", s_rdy, 1'b0);
                    check_output("rst_busy", busy, 1'b0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    aborted = 1'b1;
                    break;
                end
            end
        end
        if (!aborted && beat < nbeats) begin
            checks++;
            errors++;
            $display("[TB] FAIL pkt_timeout: got %0d beats, expected %0d", beat, nbeats);
        end
        s_vld = 1'b0;
        s_sop = 1'b0;
        s_eop = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ch, cyc, n0;
        int exp_rot[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_skip[4] = '{1, 3, 0, 1};
        logic [CH-1:0] skip_avail[4] = '{4'b1010, 4'b1010, 4'b1111, 4'b1010};

        rst = 1'b1;
        s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_dat = '0;
        ch_avail = '1;
        m_rdy = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_s_rdy", s_rdy, 1'b0);
        check_output("reset_m_vld", m_vld, 4'b0000);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_cur_id", cur_id, 2'd0);
        check_output("reset_dbg", dbg_sig, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] rotation");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 64'h100 + DW'(i), exp_rot[i], -1, 0, 1'b0, 1'b0, -1, ch, cyc);
            check_output("rot_ch", ch, exp_rot[i]);
            check_output("rot_cycles", cyc, 2);
        end
        @(negedge clk);
        check_output("rot_pkt_cnt", dbg_sig[15:0], 16'd8);
        @(posedge clk); #1;

        $display("[TB] skipping");
        for (int i = 0; i < 4; i++) begin
            ch_avail = skip_avail[i];
            apply_stimulus(1, 64'h200 + DW'(i), exp_skip[i], -1, 0, 1'b0, 1'b0, -1, ch, cyc);
            check_output("skip_ch", ch, exp_skip[i]);
        end

        $display("[TB] lock and backpressure");
        ch_avail = '1;
        n0 = log_ch.size();
        apply_stimulus(4, 64'hA000, 2, 2, 3, 1'b1, 1'b0, -1, ch, cyc);
        check_output("lock_ch", ch, 2);
        check_output("lock_cycles", cyc, 8);
        check_output("lock_beats", log_ch.size() - n0, 4);
        if (log_ch.size() >= n0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                check_output("lock_beat_ch", log_ch[n0 + i], 2);
                check_output("lock_beat_dat", log_dat[n0 + i], 64'hA000 + DW'(i));
            end
        end

        $display("[TB] no channel available");
        ch_avail = '0;
        s_vld = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_dat = 64'hB0;
        repeat (10) begin
            @(negedge clk);
            check_output("noavail_s_rdy", s_rdy, 1'b0);
            check_output("noavail_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        ch_avail = 4'b0100;
        @(negedge clk);
        check_output("avail_sel_s_rdy", s_rdy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("avail_busy", busy, 1'b1);
        check_output("avail_cur_id", cur_id, 2'd2);
        check_output("avail_m_vld", m_vld, 4'b0100);
        check_output("avail_s_rdy", s_rdy, 1'b1);
        @(posedge clk); #1;
        s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        ch_avail = '1;

        $display("[TB] protocol errors");
        s_vld = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_dat = 64'hE1;
        @(negedge clk);
        check_output("orphan_s_rdy", s_rdy, 1'b1);
        check_output("orphan_busy", busy, 1'b0);
        @(posedge clk); #1;
        s_vld = 1'b0;
        @(negedge clk);
        check_output("err_one", dbg_sig[23:16], 8'd1);
        @(posedge clk); #1;
        n0 = log_ch.size();
        apply_stimulus(3, 64'hC000, 3, -1, 0, 1'b0, 1'b1, -1, ch, cyc);
        check_output("nest_ch", ch, 3);
        check_output("nest_beats", log_ch.size() - n0, 3);
        for (int i = n0; i < log_ch.size(); i++) check_output("nest_beat_ch", log_ch[i], 3);
        @(negedge clk);
        check_output("err_two", dbg_sig[23:16], 8'd2);
        @(posedge clk); #1;
        s_vld = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_dat = 64'hE2;
        repeat (300) @(posedge clk);
        #1;
        s_vld = 1'b0;
        @(negedge clk);
        check_output("err_sat", dbg_sig[23:16], 8'hFF);
        @(posedge clk); #1;

        $display("[TB] reset mid-packet");
        apply_stimulus(1, 64'hD0, 0, -1, 0, 1'b0, 1'b0, -1, ch, cyc);
        check_output("pre_rst_ch", ch, 0);
        apply_stimulus(5, 64'hD100, 1, -1, 0, 1'b0, 1'b0, 2, ch, cyc);
        check_output("abort_ch", ch, 1);
        @(negedge clk);
        check_output("post_rst_pkt", dbg_sig[15:0], 16'd0);
        check_output("post_rst_err", dbg_sig[23:16], 8'd0);
        @(posedge clk); #1;
        apply_stimulus(1, 64'hD200, 0, -1, 0, 1'b0, 1'b0, -1, ch, cyc);
        check_output("post_rst_ch", ch, 0);
        @(negedge clk);
        check_output("post_rst_pkt_one", dbg_sig[15:0], 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_disp.md
Name: rr_disp

Overview:
- Round-robin packet dispatcher: the 1-to-N counterpart of the N-to-1 round-robin arbiter.
- Takes a single packet stream and steers each whole packet to one of CH_NUM downstream channels, e.g. parallel TOE processing engines.
- Channel choice is round-robin over the channels that report a free slot.
- The selection is locked from sop to eop so packets are never interleaved.

Parameters:
- CH_NUM, 4: number of downstream channels, 2..16.
- ID_WID, clogb2(CH_NUM): width of the channel id.
- DAT_WID, 64: packet data width.
- DBG_WID, 32: debug bus width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_vld  in  1  upstream beat valid.
- s_sop  in  1  first beat of packet.
- s_eop  in  1  last beat of packet.
- s_dat  in  DAT_WID  upstream data.
- s_rdy  out  1  upstream ready.
- ch_avail  in  CH_NUM  per-channel "can take a new packet".
- m_vld  out  CH_NUM  per-channel beat valid, one-hot or zero.
- m_sop  out  1  broadcast sop.
- m_eop  out  1  broadcast eop.
- m_dat  out  DAT_WID  broadcast data.
- m_rdy  in  CH_NUM  per-channel ready.
- cur_id  out  ID_WID  channel currently owning the stream.
- busy  out  1  a packet is in flight.
- dbg_sig  out  DBG_WID  debug.

Behaviour:
- Beat transfer on the upstream side: s_vld & s_rdy.
- Beat transfer on channel k: m_vld[k] & m_rdy[k].
- m_dat, m_sop and m_eop equal s_dat, s_sop and s_eop combinationally. Datapath latency is 0 once a channel is locked.

Registers:
- state: IDLE or XFER.
- sel_id: locked channel.
- last_id: last channel to finish a packet.
- pkt_cnt: 16-bit, wraps.
- err_cnt: 8-bit, saturates at 8'hFF.

Reset values:
- state=IDLE, sel_id=0, last_id=CH_NUM-1, pkt_cnt=0, err_cnt=0.
- With last_id=CH_NUM-1, the first search starts at channel 0.
- Outputs at reset: s_rdy=0, m_vld=0, busy=0, cur_id=0.

IDLE state:
- m_vld=0, busy=0.
- s_vld & s_sop & (ch_avail!=0): select the first k with ch_avail[k]=1, searching in order last_id+1 ... CH_NUM-1, 0 ... last_id (wrap-around). Register sel_id<=k and go to XFER. s_rdy=0 in this cycle. Selection costs exactly 1 cycle per packet.
- s_vld & s_sop & (ch_avail==0): hold with s_rdy=0 and no state change.
- s_vld & ~s_sop (orphan beat): s_rdy=1, the beat is dropped, err_cnt increments (saturating). Stay in IDLE.
- ~s_vld: s_rdy=0.

XFER state:
- busy=1, cur_id=sel_id.
- m_vld[sel_id]=s_vld; all other m_vld bits are 0.
- s_rdy=m_rdy[sel_id].
- Transfer with s_eop=1: last_id<=sel_id, pkt_cnt increments, go to IDLE.
- Transfer with s_sop=1 after the first beat (nested sop): forwarded unchanged and err_cnt increments. No packet split.
- ch_avail is ignored in XFER; deassertion mid-packet does not abort.

Other boundaries:
- Single-beat packet (sop & eop on the same beat): IDLE to XFER to IDLE. Minimum of 2 cycles per packet.
- Back-to-back packets: always exactly 1 idle cycle between the eop beat and the next sop beat.
- Only a granted packet updates last_id. A channel that was skipped because it was not available gets priority on the next search.
- Reset mid-packet: return to IDLE immediately. The partial packet is truncated at the channel with no eop, and downstream must tolerate this.

Debug:
- dbg_sig[15:0]=pkt_cnt.
- dbg_sig[23:16]=err_cnt.
- dbg_sig[24]=state.
- dbg_sig[31:25]=sel_id, zero-extended.
- When DBG_WID is narrower than 32, the upper fields are truncated.

Test Plan:
- Rotation: CH_NUM=4, ch_avail=4'hF, m_rdy=4'hF, 8 single-beat packets -> channels in order 0,1,2,3,0,1,2,3; pkt_cnt=8; each packet takes 2 cycles.
- Skipping: ch_avail=4'b1010, 3 packets -> channels 1,3,1; set ch_avail=4'hF after the packet on ch3 -> next packet goes to ch0.
- Lock and backpressure: 4-beat packet to ch2, m_rdy[2] low for 3 cycles mid-packet, ch_avail[2] dropped after sop -> s_rdy=0 during the stall, all 4 beats arrive at ch2 in order, m_vld for other channels stays 0.
- No channel available: ch_avail=0 with sop pending for 10 cycles -> s_rdy=0, busy=0; set ch_avail=4'b0100 -> selection next cycle, packet goes to ch2.
- Protocol errors: orphan beat with no sop in IDLE -> consumed, err_cnt=1; nested sop inside a packet -> err_cnt=2, packet still delivered to one channel; 300 orphans -> err_cnt=8'hFF.
- Reset: assert rst after beat 2 of a 5-beat packet to ch1 -> m_vld=0 and s_rdy=0 immediately, last_id=3; next packet goes to ch0.
